// File: rtl/mem_combinational_mp.sv
// Multi-write-port, lane-maskable memory with combinational reads and a built-in clear sequencer.
// Higher-index write ports win per lane; all outputs read CLEAR_VALUE while a clear sweep runs.
module mem_combinational_mp #(
    parameter CLOCK_INFO = 'b0,
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int READ_PORTS = 2,
    parameter int WRITE_PORTS = 2,
    parameter bit READ_BYPASS = 1'b0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int MASK_WIDTH = DATA_WIDTH / LANE_WIDTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [WRITE_PORTS-1:0]                        write_enable,
    input  logic [WRITE_PORTS-1:0][MASK_WIDTH-1:0]        write_mask,
    input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]        write_addr,
    input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]        write_data_in,
    output logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]        write_data_out,
    input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]         read_addr,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]         read_data_out,
    input  logic                                          clear_request,
    output logic                                          reset_done
);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]                mem_q [DEPTH];
    logic [WRITE_PORTS-1:0][MASK_WIDTH-1:0] wr_lane_acc;
    logic                                 ready;
    logic                                 unused_clock_info;

    assign unused_clock_info = ^CLOCK_INFO;
    assign ready             = (state_q == ST_READY);
    assign reset_done        = ready;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_EXT;
    endfunction

    always_comb begin
        wr_lane_acc = '0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (ready && write_enable[p] && in_range(write_addr[p])) begin
                wr_lane_acc[p] = write_mask[p];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (clear_request) begin
                    state_d = ST_CLEAR;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Ascending port order in one block lets the last (highest-index) NBA win each lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_cnt_q] <= CLEAR_VALUE;
            end else begin
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    for (int l = 0; l < MASK_WIDTH; l++) begin
                        if (wr_lane_acc[p][l]) begin
                            mem_q[write_addr[p]][l*LANE_WIDTH +: LANE_WIDTH] <=
                                write_data_in[p][l*LANE_WIDTH +: LANE_WIDTH];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        read_data_out = '0;
        for (int r = 0; r < READ_PORTS; r++) begin
            if (!ready) begin
                read_data_out[r] = CLEAR_VALUE;
            end else if (in_range(read_addr[r])) begin
                read_data_out[r] = mem_q[read_addr[r]];
                if (READ_BYPASS) begin
                    for (int p = 0; p < WRITE_PORTS; p++) begin
                        for (int l = 0; l < MASK_WIDTH; l++) begin
                            if (wr_lane_acc[p][l] && (write_addr[p] == read_addr[r])) begin
                                read_data_out[r][l*LANE_WIDTH +: LANE_WIDTH] =
                                    write_data_in[p][l*LANE_WIDTH +: LANE_WIDTH];
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        write_data_out = '0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (!ready) begin
                write_data_out[p] = CLEAR_VALUE;
            end else if (in_range(write_addr[p])) begin
                write_data_out[p] = mem_q[write_addr[p]];
            end
        end
    end

endmodule

// File: tb/tb_mem_combinational_mp.sv
// Scoreboard bench: driver pushes model-predicted outputs per cycle, a negedge monitor pops and compares.
// Two instances (bypass on/off) share all stimulus.
module tb_mem_combinational_mp;

    localparam int DEPTH = 20;
    localparam int WP    = 3;
    localparam int RP    = 2;
    localparam logic [31:0] CV = 32'hA5A5_A5A5;

    logic clk = 1'b1;
    logic rst;
    logic [WP-1:0]        we;
    logic [WP-1:0][3:0]   wm;
    logic [WP-1:0][4:0]   wa;
    logic [WP-1:0][31:0]  wd;
    logic [RP-1:0][4:0]   ra;
    logic                 clr_req;
    logic [WP-1:0][31:0]  wdo_b, wdo_n;
    logic [RP-1:0][31:0]  rd_b, rd_n;
    logic                 done_b, done_n;

    always #5 clk = ~clk;

    mem_combinational_mp #(
        .DATA_WIDTH(32), .LANE_WIDTH(8), .DEPTH(DEPTH), .READ_PORTS(RP),
        .WRITE_PORTS(WP), .READ_BYPASS(1'b1), .CLEAR_VALUE(CV)
    ) u_byp (
        .clk(clk), .rst(rst), .write_enable(we), .write_mask(wm), .write_addr(wa),
        .write_data_in(wd), .write_data_out(wdo_b), .read_addr(ra),
        .read_data_out(rd_b), .clear_request(clr_req), .reset_done(done_b)
    );

    mem_combinational_mp #(
        .DATA_WIDTH(32), .LANE_WIDTH(8), .DEPTH(DEPTH), .READ_PORTS(RP),
        .WRITE_PORTS(WP), .READ_BYPASS(1'b0), .CLEAR_VALUE(CV)
    ) u_nobyp (
        .clk(clk), .rst(rst), .write_enable(we), .write_mask(wm), .write_addr(wa),
        .write_data_in(wd), .write_data_out(wdo_n), .read_addr(ra),
        .read_data_out(rd_n), .clear_request(clr_req), .reset_done(done_n)
    );

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: abstract memory, ready flag and clear position.
    logic [31:0] m_mem [DEPTH];
    bit          m_ready = 1'b0;
    int          m_cpos  = 0;

    function automatic logic [31:0] m_read(input int addr, input bit byp);
        logic [31:0] v;
        if (!m_ready) return CV;
        if (addr >= DEPTH) return 32'h0;
        v = m_mem[addr];
        if (byp) begin
            for (int p = 0; p < WP; p++)
                if (we[p] && int'(wa[p]) == addr)
                    for (int l = 0; l < 4; l++)
                        if (wm[p][l]) v[8*l +: 8] = wd[p][8*l +: 8];
        end
        return v;
    endfunction

    function automatic logic [31:0] m_wdo(input int addr);
        if (!m_ready) return CV;
        if (addr >= DEPTH) return 32'h0;
        return m_mem[addr];
    endfunction

    task automatic model_edge();
        if (!rst) begin
            m_ready = 1'b0;
            m_cpos  = 0;
        end else if (!m_ready) begin
            m_mem[m_cpos] = CV;
            m_cpos++;
            if (m_cpos == DEPTH) begin
                m_ready = 1'b1;
                m_cpos  = 0;
            end
        end else begin
            for (int p = 0; p < WP; p++)
                if (we[p] && int'(wa[p]) < DEPTH)
                    for (int l = 0; l < 4; l++)
                        if (wm[p][l]) m_mem[wa[p]][8*l +: 8] = wd[p][8*l +: 8];
            if (clr_req) m_ready = 1'b0;
        end
    endtask

    typedef struct packed {
        logic               done;
        logic [RP-1:0][31:0] rb;
        logic [RP-1:0][31:0] rn;
        logic [WP-1:0][31:0] wo;
    } exp_t;

    exp_t exp_q [$];

    task automatic push_expected();
        exp_t e;
        e.done = m_ready;
        for (int r = 0; r < RP; r++) begin
            e.rb[r] = m_read(int'(ra[r]), 1'b1);
            e.rn[r] = m_read(int'(ra[r]), 1'b0);
        end
        for (int p = 0; p < WP; p++) e.wo[p] = m_wdo(int'(wa[p]));
        exp_q.push_back(e);
    endtask

    task automatic step();
        push_expected();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we = '0; wm = '0; wa = '0; wd = '0; clr_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("done_byp", {31'b0, done_b}, {31'b0, e.done});
            chk("done_nobyp", {31'b0, done_n}, {31'b0, e.done});
            for (int r = 0; r < RP; r++) begin
                chk($sformatf("rd_byp[%0d]", r), rd_b[r], e.rb[r]);
                chk($sformatf("rd_nobyp[%0d]", r), rd_n[r], e.rn[r]);
            end
            for (int p = 0; p < WP; p++) begin
                chk($sformatf("wdo_byp[%0d]", p), wdo_b[p], e.wo[p]);
                chk($sformatf("wdo_nobyp[%0d]", p), wdo_n[p], e.wo[p]);
            end
        end
    end

    initial begin
        rst = 1'b0;
        idle();
        ra = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        @(posedge clk);
        #1;
        step();
        step();
        chk("reset_done_in_reset", {31'b0, done_n}, 32'h0);
        chk("reset_read_override", rd_n[0], CV);
        chk("reset_wdo_override", wdo_b[0], CV);

        // Initial clear: ready exactly DEPTH edges after release.
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ra[0] = 5'd25;
            ra[1] = 5'(i);
            step();
            chk("init_clear_timing", {31'b0, done_n}, {31'b0, (i == DEPTH - 1)});
        end
        for (int i = 0; i < DEPTH / 2; i++) begin
            ra[0] = 5'(2 * i);
            ra[1] = 5'(2 * i + 1);
            #1;
            chk("cleared_entry_even", rd_n[0], CV);
            chk("cleared_entry_odd", rd_n[1], CV);
            step();
        end
        ra[0] = 5'd25;
        #1;
        chk("out_of_range_read", rd_n[0], 32'h0);
        step();

        // Lane merge on a same-address conflict.
        we = 3'b011;
        wa[0] = 5'd3; wm[0] = 4'b1111; wd[0] = 32'h1111_1111;
        wa[1] = 5'd3; wm[1] = 4'b0101; wd[1] = 32'h2222_2222;
        step();
        idle();
        ra[0] = 5'd3;
        #1;
        chk("lane_merge_nobyp", rd_n[0], 32'h1122_1122);
        chk("lane_merge_byp", rd_b[0], 32'h1122_1122);
        step();

        // Same-cycle bypass vs registered read.
        we = 3'b001; wa[0] = 5'd7; wm[0] = 4'b1111; wd[0] = 32'hDEAD_BEEF;
        ra[0] = 5'd7;
        #1;
        chk("bypass_same_cycle", rd_b[0], 32'hDEAD_BEEF);
        chk("nobypass_old_value", rd_n[0], CV);
        chk("wdo_no_bypass", wdo_b[0], CV);
        step();
        idle();
        #1;
        chk("nobypass_next_cycle", rd_n[0], 32'hDEAD_BEEF);
        step();

        // Runtime clear with a coincident write; writes during clear are dropped.
        for (int i = 0; i < 5; i++) begin
            we = 3'b001; wa[0] = 5'(10 + i); wm[0] = 4'hF; wd[0] = $urandom;
            step();
        end
        we = 3'b001; wa[0] = 5'd9; wm[0] = 4'hF; wd[0] = 32'h9999_9999; clr_req = 1'b1;
        step();
        chk("clear_req_drops_done", {31'b0, done_n}, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            we = 3'($urandom); wm = 12'($urandom);
            for (int p = 0; p < WP; p++) begin
                wa[p] = 5'($urandom_range(0, DEPTH - 1));
                wd[p] = $urandom;
            end
            ra[0] = 5'(i);
            step();
            chk("runtime_clear_timing", {31'b0, done_n}, {31'b0, (i == DEPTH - 1)});
        end
        idle();
        for (int i = 0; i < DEPTH / 2; i++) begin
            ra[0] = 5'(2 * i);
            ra[1] = 5'(2 * i + 1);
            #1;
            chk("post_clear_even", rd_n[0], CV);
            chk("post_clear_odd", rd_n[1], CV);
            step();
        end

        // Reset mid-clear restarts the sweep.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("restart_clear_timing", {31'b0, done_n}, {31'b0, (i == DEPTH - 1)});
        end

        // Random traffic including out-of-range addresses, collisions, clears and resets.
        for (int c = 0; c < 10000; c++) begin
            rst     = ($urandom_range(0, 999) != 0);
            clr_req = ($urandom_range(0, 399) == 0);
            we      = 3'($urandom);
            wm      = 12'($urandom);
            for (int p = 0; p < WP; p++) begin
                wa[p] = 5'($urandom_range(0, 31));
                wd[p] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) wa[1] = wa[0];
            if ($urandom_range(0, 3) == 0) wa[2] = wa[1];
            for (int r = 0; r < RP; r++) ra[r] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) ra[0] = wa[2];
            if ($urandom_range(0, 2) == 0) ra[1] = wa[0];
            step();
        end
        rst = 1'b1;
        idle();
        step();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
